// File: rtl/uart_rx_cfg_if.sv
// Receiver-side bundle for uart_rx_cfg: serial line, frame configuration
// and decoded results. The master side drives the line and configuration;
// the slave side is the receiver itself.
// BRK_DET exists only when UART_RX_BREAK_DET_EN is defined.
interface uart_rx_cfg_if #(
    parameter int DATA_WIDTH      = 8,
    parameter int PRESCALER_WIDTH = 6
);
    logic                       RX_IN;
    logic [PRESCALER_WIDTH-1:0] Prescale;
    logic [3:0]                 DATA_LEN;
    logic                       PAR_EN;
    logic                       PAR_TYP;
    logic                       STOP2;
    logic [DATA_WIDTH-1:0]      P_DATA;
    logic                       DATA_VALID;
    logic                       PAR_ERR;
    logic                       STP_ERR;
    logic                       BUSY;
`ifdef UART_RX_BREAK_DET_EN
    logic                       BRK_DET;
`endif

    modport master (
        output RX_IN, Prescale, DATA_LEN, PAR_EN, PAR_TYP, STOP2,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY
`ifdef UART_RX_BREAK_DET_EN
        , input BRK_DET
`endif
    );

    modport slave (
        input  RX_IN, Prescale, DATA_LEN, PAR_EN, PAR_TYP, STOP2,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR, BUSY
`ifdef UART_RX_BREAK_DET_EN
        , output BRK_DET
`endif
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: runtime data length (5..DATA_WIDTH), optional
// parity, one or two stop bits, 3-sample majority voting per bit and a
// 2-flop input synchroniser. Frame configuration is captured when a start
// edge is accepted so it cannot change under a frame in flight.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_cfg #(
    parameter int DATA_WIDTH      = 8,
    parameter int PRESCALER_WIDTH = 6
) (
    input  logic         CLK,
    input  logic         RST,
    uart_rx_cfg_if.slave bus
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

    localparam logic [PRESCALER_WIDTH-1:0] EDGE_ONE = {{(PRESCALER_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRESCALER_WIDTH-1:0] EDGE_TWO = {{(PRESCALER_WIDTH-2){1'b0}}, 2'b10};
    localparam logic [3:0]                 LEN_MIN  = 4'd5;
    localparam logic [3:0]                 LEN_MAX  = 4'(DATA_WIDTH);

    state_t                     state, state_nxt;
    logic                       rx_m, rx_s;
    logic [PRESCALER_WIDTH-1:0] edge_cnt, pre_q, mid;
    logic [3:0]                 bit_cnt, len_q;
    logic                       par_en_q, par_typ_q, stop2_q;
    logic [2:0]                 smp;
    logic                       maj;
    logic [DATA_WIDTH-1:0]      data_r;
    logic                       par_flag, stp_flag;
    logic                       edge_last, at_dec, last_data, last_stop, start_det;
    logic                       busy, valid_nxt, par_err_nxt, stp_err_nxt;
    logic [DATA_WIDTH-1:0]      p_data_q;
    logic                       data_valid_q, par_err_q, stp_err_q;
    logic                       brk_hold;
`ifdef UART_RX_BREAK_DET_EN
    logic                       par_bit, brk_cond, brk_nxt, brk_q;
`endif

    assign mid       = pre_q >> 1;
    assign edge_last = (edge_cnt == pre_q - EDGE_ONE);
    assign at_dec    = (edge_cnt == mid + EDGE_TWO);
    assign maj       = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
    assign last_data = (bit_cnt == len_q - 4'd1);
    assign last_stop = (bit_cnt == {3'b000, stop2_q});
    assign start_det = ~rx_s & ~brk_hold;
`ifdef UART_RX_BREAK_DET_EN
    assign brk_cond  = (data_r == '0) & (~par_en_q | ~par_bit) & stp_flag;
`else
    assign brk_hold  = 1'b0;
`endif

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= bus.RX_IN;
            rx_s <= rx_m;
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state decision; the detection cycle counts as edge 0 of the start bit
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_det) state_nxt = START;
            START:   if (at_dec && maj) state_nxt = IDLE;
                     else if (edge_last) state_nxt = DATA;
            DATA:    if (edge_last && last_data) state_nxt = par_en_q ? PARITY : STOP;
            PARITY:  if (edge_last) state_nxt = STOP;
            STOP:    if (at_dec && last_stop) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame outcome decode, active only in the single DONE cycle
    always_comb begin
        busy        = (state != IDLE);
        valid_nxt   = 1'b0;
        par_err_nxt = 1'b0;
        stp_err_nxt = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        brk_nxt     = 1'b0;
`endif
        if (state == DONE) begin
            valid_nxt   = ~par_flag & ~stp_flag;
            par_err_nxt = par_flag;
`ifdef UART_RX_BREAK_DET_EN
            brk_nxt     = brk_cond;
            stp_err_nxt = stp_flag & ~brk_cond;
`else
            stp_err_nxt = stp_flag;
`endif
        end
    end

    // Bit timing, majority sampling, data assembly and error flags
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            pre_q     <= '0;
            len_q     <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            stop2_q   <= 1'b0;
            smp       <= '0;
            data_r    <= '0;
            par_flag  <= 1'b0;
            stp_flag  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            par_bit   <= 1'b0;
            brk_hold  <= 1'b0;
`endif
        end else if (state == IDLE) begin
            bit_cnt <= '0;
            if (start_det) begin
                edge_cnt  <= EDGE_ONE;
                pre_q     <= bus.Prescale;
                len_q     <= (bus.DATA_LEN < LEN_MIN || bus.DATA_LEN > LEN_MAX) ? LEN_MAX : bus.DATA_LEN;
                par_en_q  <= bus.PAR_EN;
                par_typ_q <= bus.PAR_TYP;
                stop2_q   <= bus.STOP2;
                data_r    <= '0;
                par_flag  <= 1'b0;
                stp_flag  <= 1'b0;
            end
`ifdef UART_RX_BREAK_DET_EN
            // After a break the line must be high for a whole bit before re-arming
            else if (brk_hold) begin
                if (!rx_s)                              edge_cnt <= '0;
                else if (edge_cnt == pre_q - EDGE_ONE) brk_hold <= 1'b0;
                else                                    edge_cnt <= edge_cnt + EDGE_ONE;
            end
`endif
        end else begin
            edge_cnt <= edge_last ? '0 : edge_cnt + EDGE_ONE;
            if (edge_cnt == mid - EDGE_ONE) smp[0] <= rx_s;
            if (edge_cnt == mid)            smp[1] <= rx_s;
            if (edge_cnt == mid + EDGE_ONE) smp[2] <= rx_s;
            case (state)
                DATA: begin
                    if (at_dec) begin
                        for (int i = 0; i < DATA_WIDTH; i++)
                            if (int'(bit_cnt) == i) data_r[i] <= maj;
                    end
                    if (edge_last) bit_cnt <= last_data ? 4'd0 : bit_cnt + 4'd1;
                end
                PARITY: begin
                    if (at_dec) begin
                        par_flag <= maj ^ (^data_r) ^ par_typ_q;
`ifdef UART_RX_BREAK_DET_EN
                        par_bit  <= maj;
`endif
                    end
                end
                STOP: begin
                    if (at_dec && !maj) stp_flag <= 1'b1;
                    if (edge_last)      bit_cnt  <= bit_cnt + 4'd1;
                end
`ifdef UART_RX_BREAK_DET_EN
                DONE: begin
                    edge_cnt <= '0;
                    if (brk_cond) brk_hold <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    // Output registers: data and result pulses become visible together
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk_q        <= 1'b0;
`endif
        end else begin
            if (state == DONE) p_data_q <= data_r;
            data_valid_q <= valid_nxt;
            par_err_q    <= par_err_nxt;
            stp_err_q    <= stp_err_nxt;
`ifdef UART_RX_BREAK_DET_EN
            brk_q        <= brk_nxt;
`endif
        end
    end

    assign bus.P_DATA     = p_data_q;
    assign bus.DATA_VALID = data_valid_q;
    assign bus.PAR_ERR    = par_err_q;
    assign bus.STP_ERR    = stp_err_q;
    assign bus.BUSY       = busy;
`ifdef UART_RX_BREAK_DET_EN
    assign bus.BRK_DET    = brk_q;
`endif
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: each frame sent pushes its expected
// outcome; a monitor pops and compares whenever a result pulse appears.
module tb_uart_rx_cfg;
    localparam int DW = 8;
    localparam int PW = 6;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          v;
        logic          pe;
        logic          se;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    uart_rx_cfg_if #(.DATA_WIDTH(DW), .PRESCALER_WIDTH(PW)) bus ();

    uart_rx_cfg #(.DATA_WIDTH(DW), .PRESCALER_WIDTH(PW)) dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: any result pulse must match the oldest outstanding frame
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && (bus.DATA_VALID || bus.PAR_ERR || bus.STP_ERR)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pulse: got data=0x%0h v=%0b pe=%0b se=%0b, expected no pulse",
                         bus.P_DATA, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR);
            end else begin
                e = exp_q.pop_front();
                check("frame_result {data,valid,par_err,stp_err}",
                      {21'd0, bus.P_DATA, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR},
                      {21'd0, e.d, e.v, e.pe, e.se});
            end
        end
    end

    function automatic int eff_len(input logic [3:0] l);
        return (l < 4'd5 || int'(l) > DW) ? DW : int'(l);
    endfunction

    task automatic tick(input logic b);
        bus.RX_IN = b;
        @(posedge clk);
        #1;
    endtask

    // Serialises one frame at 'pre' clocks per bit. bad_par flips the parity
    // bit; s1/s2b are the stop bit levels; glitch_bit gets a one-clock low at
    // mid-bit; chg_len_bit rewrites DATA_LEN; abort_bit resets the DUT there.
    task automatic send_frame(input int pre, input logic [3:0] len_in, input logic [DW-1:0] data,
                              input bit pen, input bit ptyp, input bit st2, input bit bad_par,
                              input bit s1, input bit s2b,
                              input int glitch_bit, input int chg_len_bit, input int abort_bit);
        int            len;
        logic [DW-1:0] d;
        bit            bits[$];
        exp_t          e;
        len = eff_len(len_in);
        d   = '0;
        for (int i = 0; i < len; i++) d[i] = data[i];
        bits.push_back(1'b0);
        for (int i = 0; i < len; i++) bits.push_back(d[i]);
        if (pen) bits.push_back((^d) ^ ptyp ^ bad_par);
        bits.push_back(s1);
        if (st2) bits.push_back(s2b);
        e.d  = d;
        e.pe = pen && bad_par;
        e.se = !s1 || (st2 && !s2b);
        e.v  = !e.pe && !e.se;
        bus.Prescale = PW'(pre);
        bus.DATA_LEN = len_in;
        bus.PAR_EN   = pen;
        bus.PAR_TYP  = ptyp;
        bus.STOP2    = st2;
        if (abort_bit < 0) exp_q.push_back(e);
        for (int b = 0; b < bits.size(); b++) begin
            if (b == abort_bit) begin
                rst_n      = 1'b0;
                bus.RX_IN  = 1'b1;
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("reset_mid P_DATA", 32'(bus.P_DATA), 32'd0);
                check("reset_mid BUSY", 32'(bus.BUSY), 32'd0);
                check("reset_mid pulses", {29'd0, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR}, 32'd0);
                rst_n = 1'b1;
                repeat (2 * pre) @(posedge clk);
                #1;
                return;
            end
            if (b == chg_len_bit) bus.DATA_LEN = 4'd5;
            for (int c = 0; c < pre; c++)
                tick((b == glitch_bit && c == pre / 2) ? 1'b0 : bits[b]);
        end
        bus.RX_IN = 1'b1;
        repeat (3 * pre) @(posedge clk);
        #1;
        check("frame_drained (outstanding results)", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.RX_IN    = 1'b1;
        bus.Prescale = PW'(16);
        bus.DATA_LEN = 4'd8;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;
        bus.STOP2    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset P_DATA", 32'(bus.P_DATA), 32'd0);
        check("reset BUSY", 32'(bus.BUSY), 32'd0);
        check("reset pulses", {29'd0, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Plain 8N1 frame
        send_frame(16, 4'd8, 8'hA5, 0, 0, 0, 0, 1, 1, -1, -1, -1);
        // 7E1 with good parity, then bad parity
        send_frame(8, 4'd7, 8'h35, 1, 0, 0, 0, 1, 1, -1, -1, -1);
        send_frame(8, 4'd7, 8'h35, 1, 0, 0, 1, 1, 1, -1, -1, -1);
        // Two stop bits, second one low
        send_frame(16, 4'd8, 8'h3C, 0, 0, 1, 0, 1, 0, -1, -1, -1);

        // Three-clock low glitch on an idle line: rejected in START
        bus.Prescale = PW'(16);
        repeat (3) tick(1'b0);
        check("glitch BUSY raised", 32'(bus.BUSY), 32'd1);
        repeat (11) tick(1'b1);
        check("glitch BUSY released", 32'(bus.BUSY), 32'd0);
        repeat (16) tick(1'b1);

        // One-clock low inside data bit 1 of 0xFF is outvoted
        send_frame(16, 4'd8, 8'hFF, 0, 0, 0, 0, 1, 1, 2, -1, -1);
        // DATA_LEN changed mid-frame has no effect on the frame in flight
        send_frame(16, 4'd8, 8'h5A, 0, 0, 0, 0, 1, 1, -1, 4, -1);
        // Reset in the middle of a frame, then a clean frame
        send_frame(16, 4'd8, 8'h77, 0, 0, 0, 0, 1, 1, -1, -1, 5);
        send_frame(16, 4'd8, 8'hC3, 0, 0, 0, 0, 1, 1, -1, -1, -1);
        // Out-of-range length clamps to the full width
        send_frame(12, 4'd3, 8'h96, 0, 0, 0, 0, 1, 1, -1, -1, -1);
        // All-zero frame with a low stop bit, odd parity
        send_frame(9, 4'd6, 8'h00, 1, 1, 0, 0, 0, 1, -1, -1, -1);
        // Minimum length, odd parity, bad parity and bad stop together
        send_frame(8, 4'd5, 8'h1B, 1, 1, 1, 1, 0, 1, -1, -1, -1);

        // Randomised frames
        for (int n = 0; n < 24; n++) begin
            int            pre;
            logic [3:0]    len_in;
            logic [DW-1:0] data;
            pre    = $urandom_range(40, 8);
            len_in = ($urandom_range(5, 0) == 0) ? 4'($urandom_range(15, 0)) : 4'($urandom_range(8, 5));
            data   = DW'($urandom);
            send_frame(pre, len_in, data,
                       1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                       ($urandom_range(3, 0) == 0),
                       ($urandom_range(7, 0) != 0), ($urandom_range(7, 0) != 0),
                       -1, -1, -1);
        end

        repeat (20) @(posedge clk);
        #1;
        check("final queue empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
